core_periph_bridge: RTL and testbench
=====================================

# core_periph_bridge

Data-side peripheral bus master sitting directly downstream of the core hazard unit. It accepts the EX-stage peripheral access flagged by `d_valid` and runs one single-beat transaction on the peripheral bus. It returns `d_ready` (with read data) so the hazard unit can release its stall. Optionally it converts a non-responding peripheral into a bus-error completion.

## Interface
- `PERIPHERAL_BASE`, 64'h2000_0000: base of the peripheral window; subtracted from `addr` to form the bus offset.
- `TIMEOUT_CYCLES`, 255: maximum wait cycles for `p_ack`; legal range 1..65535. Used only when timeout is compiled in.

Ports:
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `d_valid` in 1: peripheral access request from the hazard unit; held while the pipeline is stalled.
- `addr` in 64: EX-stage effective address.
- `EX_mem_read` in 1, `EX_mem_write` in 1: access type.
- `wdata` in 64: store data.
- `wbe` in 8: store byte enables.
- `d_ready` out 1: one-cycle completion pulse back to the hazard unit.
- `rdata` out 64: load data, valid while `d_ready`=1.
- `d_err` out 1: completion was a timeout, valid while `d_ready`=1.
- `p_req` out 1: bus request; held until acknowledged.
- `p_we` out 1: bus write.
- `p_addr` out 32: bus offset.
- `p_wdata` out 64: bus write data.
- `p_be` out 8: bus byte enables.
- `p_ack` in 1: slave acknowledge; single-cycle.
- `p_rdata` in 64: slave read data, sampled when `p_ack`=1.

## Operation
- **FSM states:** IDLE, REQ, DONE.
- **IDLE:**
  - On `d_valid`=1, latch the bus fields and go to REQ:
    - `p_we` = `EX_mem_write`.
    - `p_addr` = (`addr` − `PERIPHERAL_BASE`)[31:0].
    - `p_wdata` = `wdata`.
    - `p_be` = `wbe` on writes, 8'hFF on reads.
  - Otherwise stay in IDLE.
- **REQ:**
  - `p_req`=1 and all bus fields held stable.
  - On `p_ack`=1: capture `p_rdata` into `rdata` (on writes, `rdata` = 0) and go to DONE.
- **DONE:**
  - `d_ready`=1 for exactly this cycle.
  - `p_req`=0.
  - Unconditionally go to IDLE.
- **Re-issue prevention:** `d_valid` is still high during DONE for the same instruction; it is not sampled there, so the same access is never re-issued.
- **Read and write both asserted:** treated as a write.
- **Request withdrawn:** `d_valid` dropping while in REQ (pipeline flush) does not abort the transaction. It completes normally, and the `d_ready` pulse is harmless.
- **Stray acknowledges:** `p_ack` in IDLE or DONE is ignored.
- **Address trust:** the block does not range-check `addr`; it relies on `d_valid` already containing the range test.

## Timing
- **Reset values:** all outputs are 0; state is IDLE; timeout counter is 0.
- **Reset mid-transaction:** `rst_n` low in any state forces IDLE on the next edge and drops `p_req` immediately (registered).
- **Pipeline:**
  - `d_valid` first seen high in cycle N (IDLE).
  - `p_req` high from N+1.
  - Slave with `p_ack` in N+1: DONE in N+2, so `d_ready` is high in N+2.
  - Minimum stall is 2 cycles; each additional wait cycle adds 1.
- **Back-to-back accesses:** return to IDLE at N+3. A new `d_valid` in N+3 (the next instruction) starts a new transaction with `p_req` high in N+4.
- **Output sourcing:** `p_req`, `d_ready`, `rdata` and `d_err` are registered; no combinational path from `p_ack` to `d_ready`.

## Configuration
- Macro: `PERIPH_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to REQ and increments each REQ cycle without `p_ack`.
  - When the count reaches `TIMEOUT_CYCLES` with no `p_ack`, go to DONE with `rdata` = 64'hFFFF_FFFF_FFFF_FFFF and `d_err`=1.
  - `p_req` drops in DONE as usual.
  - `p_ack` arriving on the same cycle as expiry wins: normal completion, `d_err`=0.
- **Undefined:**
  - No counter is built; REQ waits indefinitely.
  - `d_err` is tied to 0.

## Test plan
- **Zero-wait read:** `addr`=64'h2000_0010, read, `p_ack`=1 in the first REQ cycle with `p_rdata`=64'h1234.
  - Required: `p_addr`=32'h10, `p_be`=8'hFF, `d_ready` pulses 2 cycles after `d_valid`, `rdata`=64'h1234, `d_err`=0.
- **3-wait write:** `addr`=64'h2000_0004, `wdata`=64'hAB, `wbe`=8'h0F.
  - Required: `p_we`=1 with all fields stable for 4 REQ cycles, `d_ready` 5 cycles after `d_valid`, `rdata`=0.
- **Back-to-back:** `d_valid` held through DONE, then a second access.
  - Required: exactly one bus request per access, second `p_req` in the cycle after IDLE is re-entered.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=4):** no `p_ack`.
  - Required: `d_ready`=1, `d_err`=1, `rdata` all-ones after 4 REQ cycles.
  - A late `p_ack` afterwards is ignored.
- **Reset mid-REQ:** `rst_n`=0 for 1 cycle during a wait.
  - Required: next cycle `p_req`=0, `d_ready`=0, state IDLE.
  - A fresh access then completes normally.

Source files
------------

// File: rtl/core_periph_bridge.sv
// core_periph_bridge: single-beat peripheral bus master behind the core hazard unit.
// Takes one EX-stage peripheral access, runs it on the bus and returns a one-cycle
// d_ready pulse (with load data) so the stall can be released.
// Optional feature macro: PERIPH_TIMEOUT_EN. When it is defined, a peripheral that never
// acknowledges becomes a bus-error completion after TIMEOUT_CYCLES request cycles.
// When it is undefined, REQ waits forever and d_err is tied low.
module core_periph_bridge #(
  parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic [63:0] addr,
  input  logic        EX_mem_read,
  input  logic        EX_mem_write,
  input  logic [63:0] wdata,
  input  logic [7:0]  wbe,
  output logic        d_ready,
  output logic [63:0] rdata,
  output logic        d_err,
  output logic        p_req,
  output logic        p_we,
  output logic [31:0] p_addr,
  output logic [63:0] p_wdata,
  output logic [7:0]  p_be,
  input  logic        p_ack,
  input  logic [63:0] p_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic        p_req_reg;
  logic        p_we_reg;
  logic [31:0] p_addr_reg;
  logic [63:0] p_wdata_reg;
  logic [7:0]  p_be_reg;
  logic        d_ready_reg;
  logic [63:0] rdata_reg;

  // Bus offset relative to the peripheral window; only the low 32 bits reach the bus.
  logic [63:0] offset_next;
  logic        is_read_only;
  logic [7:0]  be_next;

  assign offset_next  = addr - PERIPHERAL_BASE;
  // A write wins when both access flags are set.
  assign is_read_only = EX_mem_read & ~EX_mem_write;

  // Per-byte lane enable: reads fetch all lanes, writes use the store byte enables.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_be_lane
      assign be_next[gi] = is_read_only | (EX_mem_write & wbe[gi]);
    end
  endgenerate

`ifdef PERIPH_TIMEOUT_EN
  // Value the counter holds during the last permitted REQ cycle.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_reg;
  logic        d_err_reg;
  logic        unused_bits;
  assign unused_bits = ^offset_next[63:32];
`else
  logic        unused_bits;
  assign unused_bits = ^{offset_next[63:32], TIMEOUT_CYCLES};
`endif

  // Transaction FSM with all bus and completion outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      p_req_reg   <= 1'b0;
      p_we_reg    <= 1'b0;
      p_addr_reg  <= 32'd0;
      p_wdata_reg <= 64'd0;
      p_be_reg    <= 8'd0;
      d_ready_reg <= 1'b0;
      rdata_reg   <= 64'd0;
`ifdef PERIPH_TIMEOUT_EN
      tmo_cnt_reg <= 16'd0;
      d_err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          d_ready_reg <= 1'b0;
          if (d_valid) begin
            state_reg   <= REQ;
            p_req_reg   <= 1'b1;
            p_we_reg    <= EX_mem_write;
            p_addr_reg  <= offset_next[31:0];
            p_wdata_reg <= wdata;
            p_be_reg    <= be_next;
`ifdef PERIPH_TIMEOUT_EN
            tmo_cnt_reg <= 16'd0;
`endif
          end
        end
        REQ: begin
          // Bus fields stay frozen here; d_valid is deliberately not looked at.
          if (p_ack) begin
            state_reg   <= DONE;
            p_req_reg   <= 1'b0;
            d_ready_reg <= 1'b1;
            rdata_reg   <= p_we_reg ? 64'd0 : p_rdata;
`ifdef PERIPH_TIMEOUT_EN
            d_err_reg   <= 1'b0;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg   <= DONE;
            p_req_reg   <= 1'b0;
            d_ready_reg <= 1'b1;
            rdata_reg   <= {64{1'b1}};
            d_err_reg   <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
`endif
          end
        end
        DONE: begin
          // d_valid is still high for the same instruction here, so it is not sampled.
          state_reg   <= IDLE;
          d_ready_reg <= 1'b0;
`ifdef PERIPH_TIMEOUT_EN
          d_err_reg   <= 1'b0;
`endif
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign p_req   = p_req_reg;
  assign p_we    = p_we_reg;
  assign p_addr  = p_addr_reg;
  assign p_wdata = p_wdata_reg;
  assign p_be    = p_be_reg;
  assign d_ready = d_ready_reg;
  assign rdata   = rdata_reg;
`ifdef PERIPH_TIMEOUT_EN
  assign d_err   = d_err_reg;
`else
  assign d_err   = 1'b0;
`endif

endmodule

// File: tb/tb_core_periph_bridge.sv
// tb_core_periph_bridge: directed scoreboard bench for core_periph_bridge.
// Stimulus pushes expected bus requests and completions into queues; two monitors
// pop and compare whenever the DUT raises p_req or d_ready.
module tb_core_periph_bridge;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_valid = 1'b0;
  logic [63:0] addr = 64'd0;
  logic        EX_mem_read = 1'b0;
  logic        EX_mem_write = 1'b0;
  logic [63:0] wdata = 64'd0;
  logic [7:0]  wbe = 8'd0;
  logic        d_ready;
  logic [63:0] rdata;
  logic        d_err;
  logic        p_req;
  logic        p_we;
  logic [31:0] p_addr;
  logic [63:0] p_wdata;
  logic [7:0]  p_be;
  logic        p_ack = 1'b0;
  logic [63:0] p_rdata = 64'd0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_count = 0;
  int n_access = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } cpl_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          cyc;
  } bus_t;

  cpl_t cpl_q[$];
  bus_t bus_q[$];
  bus_t cur_bus;
  logic prev_req = 1'b0;

  core_periph_bridge #(
    .PERIPHERAL_BASE(64'h2000_0000),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_valid     (d_valid),
    .addr        (addr),
    .EX_mem_read (EX_mem_read),
    .EX_mem_write(EX_mem_write),
    .wdata       (wdata),
    .wbe         (wbe),
    .d_ready     (d_ready),
    .rdata       (rdata),
    .d_err       (d_err),
    .p_req       (p_req),
    .p_we        (p_we),
    .p_addr      (p_addr),
    .p_wdata     (p_wdata),
    .p_be        (p_be),
    .p_ack       (p_ack),
    .p_rdata     (p_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor: every d_ready pulse must match the next queued completion.
  always @(negedge clk) begin
    if (d_ready) begin
      if (cpl_q.size() == 0) begin
        check("unexpected_d_ready", 64'd1, 64'd0);
      end else begin
        cpl_t e;
        e = cpl_q.pop_front();
        check("cpl_rdata", rdata, e.rdata);
        check("cpl_err", {63'd0, d_err}, {63'd0, e.err});
        check("cpl_cycle", 64'(cyc), 64'(e.cyc));
        $display("CPL  cycle=%0d rdata=%h err=%0b", cyc, rdata, d_err);
      end
    end
  end

  // Bus monitor: a rising p_req pops one request; while it stays high the fields must hold.
  always @(negedge clk) begin
    if (p_req && !prev_req) begin
      req_count <= req_count + 1;
      if (bus_q.size() == 0) begin
        check("unexpected_p_req", 64'd1, 64'd0);
      end else begin
        bus_t b;
        b = bus_q.pop_front();
        check("req_we", {63'd0, p_we}, {63'd0, b.we});
        check("req_addr", {32'd0, p_addr}, {32'd0, b.addr});
        check("req_wdata", p_wdata, b.wdata);
        check("req_be", {56'd0, p_be}, {56'd0, b.be});
        check("req_cycle", 64'(cyc), 64'(b.cyc));
        cur_bus <= b;
        $display("REQ  cycle=%0d we=%0b addr=%h wdata=%h be=%h", cyc, p_we, p_addr, p_wdata, p_be);
      end
    end else if (p_req) begin
      check("req_stable_ctl", {23'd0, p_we, p_addr, p_be},
            {23'd0, cur_bus.we, cur_bus.addr, cur_bus.be});
      check("req_stable_wdata", p_wdata, cur_bus.wdata);
    end
    prev_req <= p_req;
  end

  // One access: waits < 0 means the slave never acknowledges.
  task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                        input logic [63:0] wd, input logic [7:0] be,
                        input logic [63:0] slave_rd, input int waits, input logic drop,
                        input logic exp_we, input logic [31:0] exp_paddr,
                        input logic [7:0] exp_be, input logic [63:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    bus_t b;
    cpl_t c;
    d_valid      = 1'b1;
    EX_mem_read  = rd;
    EX_mem_write = wr;
    addr         = a;
    wdata        = wd;
    wbe          = be;
    b.we    = exp_we;
    b.addr  = exp_paddr;
    b.wdata = wd;
    b.be    = exp_be;
    b.cyc   = cyc + 1;
    bus_q.push_back(b);
    c.rdata = exp_rdata;
    c.err   = exp_err;
    c.cyc   = cyc + exp_lat;
    cpl_q.push_back(c);
    n_access++;
    @(posedge clk); #1;
    if (drop) d_valid = 1'b0;
    if (waits >= 0) begin
      repeat (waits) begin
        @(posedge clk); #1;
      end
      p_ack   = 1'b1;
      p_rdata = slave_rd;
      @(posedge clk); #1;
      p_ack   = 1'b0;
      p_rdata = 64'd0;
    end else begin
      repeat (TMO) begin
        @(posedge clk); #1;
      end
    end
    // DUT in DONE with d_valid still held for the same instruction.
    @(posedge clk); #1;
    d_valid      = 1'b0;
    EX_mem_read  = 1'b0;
    EX_mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_t b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_req", {63'd0, p_req}, 64'd0);
    check("rst_d_ready", {63'd0, d_ready}, 64'd0);
    check("rst_d_err", {63'd0, d_err}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_bus", {23'd0, p_we, p_addr, p_be}, 64'd0);
    check("rst_p_wdata", p_wdata, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Zero-wait read.
    access(1, 0, 64'h2000_0010, 64'd0, 8'h00, 64'h1234, 0, 0,
           1'b0, 32'h10, 8'hFF, 64'h1234, 1'b0, 2);
    repeat (2) @(posedge clk);
    #1;
    // Three-wait write.
    access(0, 1, 64'h2000_0004, 64'hAB, 8'h0F, 64'hDEAD_BEEF, 3, 0,
           1'b1, 32'h4, 8'h0F, 64'd0, 1'b0, 5);
    repeat (2) @(posedge clk);
    #1;
    // Back-to-back: second access starts in the cycle IDLE is re-entered.
    access(1, 0, 64'h2000_0100, 64'd0, 8'h00, 64'h0102_0304_0506_0708, 1, 0,
           1'b0, 32'h100, 8'hFF, 64'h0102_0304_0506_0708, 1'b0, 3);
    access(0, 1, 64'h2000_0108, 64'h55, 8'hF0, 64'h9999, 0, 0,
           1'b1, 32'h108, 8'hF0, 64'd0, 1'b0, 2);
    repeat (2) @(posedge clk);
    #1;
    // Read and write both asserted behaves as a write.
    access(1, 1, 64'h2000_0020, 64'h77, 8'h3C, 64'h4444, 1, 0,
           1'b1, 32'h20, 8'h3C, 64'd0, 1'b0, 3);
    repeat (2) @(posedge clk);
    #1;
    // d_valid withdrawn during REQ: the transaction still completes.
    access(1, 0, 64'h2000_0FF8, 64'd0, 8'h00, 64'hCAFE, 2, 1,
           1'b0, 32'hFF8, 8'hFF, 64'hCAFE, 1'b0, 4);
    repeat (2) @(posedge clk);
    #1;
    // Address below the window is not range-checked; the offset wraps.
    access(1, 0, 64'h1FFF_FFF0, 64'd0, 8'h00, 64'h5A5A, 0, 0,
           1'b0, 32'hFFFF_FFF0, 8'hFF, 64'h5A5A, 1'b0, 2);
    repeat (2) @(posedge clk);
    #1;

    // Stray acknowledge in IDLE must be ignored.
    p_ack   = 1'b1;
    p_rdata = 64'hBAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    p_ack   = 1'b0;
    p_rdata = 64'd0;
    check("stray_ack_p_req", {63'd0, p_req}, 64'd0);
    check("stray_ack_d_ready", {63'd0, d_ready}, 64'd0);
    @(posedge clk); #1;

`ifdef PERIPH_TIMEOUT_EN
    // Timeout: no acknowledge, then a late one that must be ignored.
    access(1, 0, 64'h2000_0080, 64'd0, 8'h00, 64'd0, -1, 0,
           1'b0, 32'h80, 8'hFF, {64{1'b1}}, 1'b1, 1 + TMO);
    p_ack   = 1'b1;
    p_rdata = 64'h1111;
    @(posedge clk); #1;
    p_ack   = 1'b0;
    p_rdata = 64'd0;
    check("late_ack_p_req", {63'd0, p_req}, 64'd0);
    @(posedge clk); #1;
    check("late_ack_d_ready", {63'd0, d_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
`endif

    // Reset during a REQ wait.
    d_valid      = 1'b1;
    EX_mem_read  = 1'b1;
    EX_mem_write = 1'b0;
    addr         = 64'h2000_0040;
    wdata        = 64'd0;
    wbe          = 8'd0;
    b.we    = 1'b0;
    b.addr  = 32'h40;
    b.wdata = 64'd0;
    b.be    = 8'hFF;
    b.cyc   = cyc + 1;
    bus_q.push_back(b);
    n_access++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n   = 1'b0;
    d_valid = 1'b0;
    EX_mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_p_req", {63'd0, p_req}, 64'd0);
    check("midrst_d_ready", {63'd0, d_ready}, 64'd0);
    check("midrst_d_err", {63'd0, d_err}, 64'd0);
    @(posedge clk); #1;
    // Fresh access after the reset completes normally.
    access(1, 0, 64'h2000_0048, 64'd0, 8'h00, 64'h7777_0000_8888, 1, 0,
           1'b0, 32'h48, 8'hFF, 64'h7777_0000_8888, 1'b0, 3);

    repeat (5) @(posedge clk);
    #1;
    check("cpl_queue_drained", 64'(cpl_q.size()), 64'd0);
    check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    check("one_req_per_access", 64'(req_count), 64'(n_access));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
